// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: latches ADC frames on valid strobes and streams each as one AXI-Stream packet
//   clk, rst          : clock, synchronous active-high reset
//   start             : capture enable (level); frame_num sampled when capture arms (0 = continuous)
//   valid, ADC_data   : one-cycle strobe with a full WORDS*DW frame, word 0 in the low bits
//   S_AXIS_*          : AXI-Stream master, one packet of WORDS words per frame, tlast on the final word
//   busy, done        : status (busy in WAIT/SEND, done pulses on entry to DONE)
//   drop_cnt          : strobes lost while a packet was in flight, saturating
module adc_capture_sequencer #(
    parameter int WORDS = 256,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               valid,
    input  logic [WORDS*DW-1:0] ADC_data,
    input  logic [15:0]        frame_num,
    input  logic               S_AXIS_tready,
    output logic               S_AXIS_tvalid,
    output logic               S_AXIS_tlast,
    output logic [DW-1:0]      S_AXIS_tdata,
    output logic               busy,
    output logic               done,
    output logic [15:0]        drop_cnt
);
    localparam int IW = $clog2(WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, SEND, DONE} state_t;
    state_t state, state_nxt;
    logic [WORDS*DW-1:0] frame;
    logic [IW-1:0] idx, idx_inc;
    logic [15:0] cnt, cnt_inc, fnum;
    logic hs, last_hs;
    logic tvalid_nxt, tlast_nxt, busy_nxt, done_nxt;
    logic [DW-1:0] tdata_nxt;
    assign hs      = S_AXIS_tvalid && S_AXIS_tready;
    assign last_hs = hs && S_AXIS_tlast;
    assign idx_inc = idx + 1'b1;
    assign cnt_inc = cnt + 16'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            S_AXIS_tvalid <= 1'b0;
            S_AXIS_tlast  <= 1'b0;
            S_AXIS_tdata  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            drop_cnt      <= '0;
            idx           <= '0;
            cnt           <= '0;
            fnum          <= '0;
        end else begin
            state         <= state_nxt;
            S_AXIS_tvalid <= tvalid_nxt;
            S_AXIS_tlast  <= tlast_nxt;
            S_AXIS_tdata  <= tdata_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            if (state == IDLE && start) begin
                fnum     <= frame_num;
                cnt      <= '0;
                drop_cnt <= '0;
            end
            if (state == WAIT && start && valid)
                idx <= '0;
            else if (hs)
                idx <= idx_inc;
            if (last_hs)
                cnt <= cnt_inc;
            if (state == SEND && valid && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
    // The frame buffer carries no reset; it is always loaded before use.
    always_ff @(posedge clk) begin
        if (state == WAIT && start && valid)
            frame <= ADC_data;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = start ? WAIT : IDLE;
            WAIT: state_nxt = !start ? DONE : (valid ? SEND : WAIT);
            SEND: if (last_hs)
                      state_nxt = ((fnum != 16'd0 && cnt_inc == fnum) || !start) ? DONE : WAIT;
            DONE: state_nxt = start ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // Outputs are computed one cycle ahead and registered so the stream stays glitch-free.
    always_comb begin
        tvalid_nxt = state_nxt == SEND;
        busy_nxt   = state_nxt == WAIT || state_nxt == SEND;
        done_nxt   = state_nxt == DONE && state != DONE;
        tdata_nxt  = S_AXIS_tdata;
        tlast_nxt  = S_AXIS_tlast;
        if (state == WAIT && state_nxt == SEND) begin
            tdata_nxt = ADC_data[DW-1:0];
            tlast_nxt = 1'b0;
        end else if (hs && !S_AXIS_tlast) begin
            tdata_nxt = frame[int'(idx_inc)*DW +: DW];
            tlast_nxt = idx_inc == IW'(WORDS-1);
        end else if (state_nxt != SEND) begin
            tlast_nxt = 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: scoreboard bench for adc_capture_sequencer
module tb_adc_capture_sequencer;
    localparam int WORDS = 256;
    localparam int DW    = 32;
    logic clk = 0, rst = 1, start = 0, valid = 0, tready;
    logic [WORDS*DW-1:0] adc_data = '0;
    logic [15:0] frame_num = 0;
    logic tvalid, tlast, busy, done;
    logic [DW-1:0] tdata;
    logic [15:0] drop_cnt;
    logic [DW:0] q[$];
    int checks = 0, errors = 0;
    int done_cnt = 0, tlast_cnt = 0, beat_idx = 0;
    bit bp = 0, held = 0;
    logic [DW-1:0] prev_data;
    logic prev_last;

    adc_capture_sequencer #(.WORDS(WORDS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .ADC_data(adc_data),
        .frame_num(frame_num), .S_AXIS_tready(tready), .S_AXIS_tvalid(tvalid),
        .S_AXIS_tlast(tlast), .S_AXIS_tdata(tdata), .busy(busy), .done(done),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORDS*DW-1:0] build(input int seed);
        logic [WORDS*DW-1:0] f;
        for (int k = 0; k < WORDS; k++)
            f[k*DW +: DW] = (DW'(seed) << 16) | DW'(k);
        return f;
    endfunction

    task automatic strobe(input int seed, input bit acc);
        adc_data = build(seed);
        if (acc)
            for (int k = 0; k < WORDS; k++)
                q.push_back({k == WORDS-1, (DW'(seed) << 16) | DW'(k)});
        valid = 1;
        tick();
        valid = 0;
        if (acc) chk("latency_tvalid", tvalid, 1);
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, q.size(), 0);
        chk({tag, "_tvalid_after"}, tvalid, 0);
    endtask

    task automatic wait_beat(input int b, input int bound);
        int n = 0;
        while (beat_idx < b && n < bound) begin
            tick();
            n++;
        end
        chk("beat_reached", beat_idx >= b, 1);
    endtask

    initial begin
        tready = 1;
        forever begin
            @(posedge clk);
            #1;
            tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            beat_idx = 0;
            held = 0;
        end else begin
            if (done) done_cnt++;
            if (held) begin
                chk("hold_tvalid", tvalid, 1);
                chk("hold_tdata", tdata, prev_data);
                chk("hold_tlast", tlast, prev_last);
            end
            if (tvalid && tready) begin
                if (q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    logic [DW:0] e;
                    e = q.pop_front();
                    chk("tdata", tdata, e[DW-1:0]);
                    chk("tlast", tlast, e[DW]);
                end
                beat_idx = tlast ? 0 : beat_idx + 1;
                if (tlast) tlast_cnt++;
            end
            held = tvalid && !tready;
            prev_data = tdata;
            prev_last = tlast;
        end
    end

    initial begin
        int d0, t0;
        repeat (3) tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 0;
        tick();
        chk("idle_busy", busy, 0);

        // single frame, word k = k
        frame_num = 1;
        start = 1;
        tick();
        chk("busy_rise", busy, 1);
        d0 = done_cnt;
        strobe(0, 1);
        drain("single", 400);
        chk("single_busy_done", busy, 0);
        repeat (2) tick();
        chk("single_done_pulse", done_cnt - d0, 1);
        strobe(5, 0);
        repeat (5) tick();
        chk("done_hold_tvalid", tvalid, 0);
        chk("done_hold_busy", busy, 0);
        chk("done_no_retrigger", done_cnt - d0, 1);
        chk("done_ignore_drop", drop_cnt, 0);
        start = 0;
        repeat (3) tick();

        // backpressure
        bp = 1;
        start = 1;
        tick();
        strobe(1, 1);
        drain("bp", 3000);
        bp = 0;
        start = 0;
        repeat (3) tick();

        // three frames, fourth strobe ignored
        frame_num = 3;
        start = 1;
        tick();
        d0 = done_cnt;
        t0 = tlast_cnt;
        for (int i = 0; i < 4; i++) begin
            strobe(2 + i, i < 3);
            repeat (299) tick();
        end
        drain("three", 10);
        chk("three_packets", tlast_cnt - t0, 3);
        chk("three_done", done_cnt - d0, 1);
        chk("three_drop", drop_cnt, 0);
        start = 0;
        repeat (3) tick();

        // overrun: strobes at 0,100,200,300
        frame_num = 2;
        start = 1;
        tick();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            strobe(10 + i, i == 0 || i == 3);
            if (i < 3) repeat (99) tick();
        end
        drain("overrun", 400);
        tick();
        chk("overrun_drop", drop_cnt, 2);
        chk("overrun_done", done_cnt - d0, 1);
        start = 0;
        repeat (3) tick();

        // continuous mode, start dropped mid-packet
        frame_num = 0;
        start = 1;
        tick();
        d0 = done_cnt;
        t0 = tlast_cnt;
        strobe(20, 1);
        drain("cont_a", 400);
        chk("cont_busy_between", busy, 1);
        strobe(21, 1);
        wait_beat(100, 400);
        start = 0;
        drain("cont_b", 400);
        repeat (20) tick();
        strobe(22, 0);
        repeat (5) tick();
        chk("cont_packets", tlast_cnt - t0, 2);
        chk("cont_done", done_cnt - d0, 1);
        chk("cont_idle_tvalid", tvalid, 0);

        // reset mid-packet
        frame_num = 1;
        start = 1;
        tick();
        strobe(30, 1);
        wait_beat(20, 400);
        strobe(31, 0);
        wait_beat(50, 400);
        chk("pre_rst_drop", drop_cnt, 1);
        rst = 1;
        tick();
        q.delete();
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tlast", tlast, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        rst = 0;
        tick();
        d0 = done_cnt;
        strobe(32, 1);
        drain("after_rst", 400);
        repeat (2) tick();
        chk("after_rst_done", done_cnt - d0, 1);
        start = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Capture controller between the ADC front end and the AXI-Stream FIFO/DMA path. It arms on `start`, latches one complete ADC frame on each `valid` strobe, and serializes each frame into a single AXI-Stream packet of `WORDS` words with `tlast` on the final word. It repeats for a programmed number of frames, or runs continuously. It counts frames lost while a packet is in flight and reports busy/done status to software.

## Interface
- `WORDS`, 256: words per frame and per packet (≥2).
- `DW`, 32: AXI-Stream data width.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: capture enable, level-sensitive.
- `valid`  in  1: one-cycle strobe; `ADC_data` holds a complete frame in that cycle.
- `ADC_data`  in  WORDS*DW: frame; word k = bits [k*DW+DW-1 : k*DW], sent k=0 first.
- `frame_num`  in  16: frames per capture; 0 = continuous. Sampled on IDLE→WAIT.
- `S_AXIS_tready`  in  1: downstream ready.
- `S_AXIS_tvalid`  out  1: data valid.
- `S_AXIS_tlast`  out  1: last word of packet.
- `S_AXIS_tdata`  out  DW: data word.
- `busy`  out  1: high in WAIT or SEND.
- `done`  out  1: one-cycle pulse on entry to DONE.
- `drop_cnt`  out  16: frames dropped this capture; saturates at 0xFFFF.

## Operation
- Reset: state=IDLE; `S_AXIS_tvalid`, `S_AXIS_tlast`, `busy`, `done` = 0; `S_AXIS_tdata`=0; `drop_cnt`=0. Word index, frame counter and latched `frame_num` = 0. The frame buffer is not reset.
- IDLE: if `start`=1, go to WAIT. Latch `frame_num`, clear the frame counter, clear `drop_cnt`.
- WAIT:
  - If `start`=0, go to DONE.
  - Else if `valid`=1, copy `ADC_data` into the frame buffer, set word index to 0, and go to SEND.
  - `valid` and `start`=0 in the same cycle: `start` wins. The frame is ignored and not counted as a drop.
- SEND:
  - Present word[index] with `tvalid`=1 and `tlast`=(index==WORDS-1).
  - On each `tvalid && tready` handshake, index increments.
  - On the handshake of word WORDS-1, the frame counter increments. Then:
    - if `frame_num`≠0 and the new count == `frame_num`, go to DONE;
    - else if `start`=0, go to DONE;
    - else go to WAIT.
  - A `start` deassert mid-packet never truncates the packet. The current packet always completes.
- DONE:
  - `done`=1 for the entry cycle only.
  - Stay in DONE while `start`=1, then go to IDLE. This prevents re-triggering on a held `start`.
- Drops: each `valid` strobe seen while in SEND increments `drop_cnt`, saturating at 0xFFFF. Strobes in IDLE or DONE are ignored and not counted.
- Frame counter is 16-bit. In continuous mode it wraps 0xFFFF→0 with no effect on behaviour.

## Timing
- `valid` at cycle N in WAIT → `tvalid`=1 with word0 at cycle N+1. Latency is one cycle.
- `tdata`, `tlast`, `tvalid` are registered. They stay stable while `tvalid && !tready`; AXI-Stream rules apply.
- With `tready` held high, one word per cycle: a packet occupies exactly WORDS cycles.
- After the last-word handshake, `tvalid`=0 in the next cycle, in both WAIT and DONE.
- Back-to-back frames: a `valid` strobe in the cycle after the last-word handshake (state WAIT) is accepted. A strobe in the same cycle as the last-word handshake (state SEND) is a drop.
- `busy` is registered and tracks state: it rises the cycle after `start` is sampled in IDLE. It falls in the DONE entry cycle, the same cycle `done` pulses.
- `rst` mid-packet: outputs take reset values the next cycle. The packet is abandoned with no `tlast`.

## Test plan
- Single frame, `frame_num`=1, frame word k = k, `tready`=1, `start` held high: 256 beats with data 0..255, `tlast` only on beat 255. Then one `done` pulse, `busy` low, state stays DONE until `start`=0.
- Backpressure: toggle `tready` pseudo-randomly. Every beat is accepted exactly once, in order. `tdata`/`tlast` hold while `tready`=0.
- `frame_num`=3 with `valid` every 300 cycles: exactly 3 packets, each ending in `tlast`. A 4th `valid` is ignored and `drop_cnt`=0.
- Overrun: `valid` every 100 cycles, `tready`=1, `frame_num`=2. Each 256-cycle packet overlaps two subsequent strobes (e.g. cycles 100 and 200 during packet 1), giving `drop_cnt`=2 after capture; the strobe at cycle 300 starts packet 2.
- Continuous mode, `frame_num`=0: deassert `start` at beat 100 of a packet. The packet completes through beat 255 with `tlast`, then DONE with no further packets.
- Reset mid-packet at beat 50: the next cycle shows `tvalid`=0, `busy`=0, `drop_cnt`=0. A new `start` + `valid` then produces a full 256-beat packet.
